// File: rtl/m_hart_mem_arbiter_pkg.sv
// Shared FSM encodings, the no-owner grant value and the hold-counter helper
// used by the hart DRAM arbiter.
package m_hart_mem_arbiter_pkg;

   localparam logic [1:0]  ARB_IDLE    = 2'd0;
   localparam logic [1:0]  ARB_GRANT   = 2'd1;
   localparam logic [1:0]  ARB_RELEASE = 2'd2;
   localparam logic [31:0] GRANT_NONE  = 32'hFFFF_FFFF;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/m_hart_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester found searching
// upward from last_owner+1 and wrapping, so last_owner itself comes last.
module m_rr_pick #(
   parameter int NHARTS = 2,
   parameter int IW     = 1
) (
   input  logic [NHARTS-1:0] req,
   input  logic [IW-1:0]     last_owner,
   output logic [NHARTS-1:0] pick,
   output logic [IW-1:0]     pick_idx
);

   always_comb begin
      int best_d;
      int d;
      pick     = '0;
      pick_idx = '0;
      best_d   = NHARTS;
      d        = 0;
      for (int i = 0; i < NHARTS; i++) begin
         // distance of hart i from the slot just after last_owner
         d = (i + 2 * NHARTS - int'(last_owner) - 1) % NHARTS;
         if (req[i] && d < best_d) begin
            best_d   = d;
            pick     = '0;
            pick[i]  = 1'b1;
            pick_idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/m_hart_mem_arbiter.sv
// Round-robin owner of the single DRAM port for NHARTS MMUs; the owner keeps
// the port until it drops its request while DRAM is idle, then one dead cycle.
module m_hart_mem_arbiter
   import m_hart_mem_arbiter_pkg::*;
#(
   parameter int NHARTS   = 2,
   parameter int MAX_HOLD = 4096
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NHARTS-1:0]      w_req,
   input  logic [NHARTS*32-1:0]   w_h_addr,
   input  logic [NHARTS*32-1:0]   w_h_wdata,
   input  logic [NHARTS-1:0]      w_h_we,
   input  logic [NHARTS-1:0]      w_h_le,
   input  logic [NHARTS*3-1:0]    w_h_ctrl,
   output logic [NHARTS-1:0]      w_h_busy,
   output logic [NHARTS-1:0]      w_gnt,
   output logic [31:0]            w_grant,
   output logic [31:0]            w_dram_addr,
   output logic [31:0]            w_dram_wdata,
   output logic                   w_dram_we,
   output logic                   w_dram_le,
   output logic [2:0]             w_dram_ctrl,
   input  logic                   w_dram_busy,
   output logic                   w_hold_err
);

   localparam int IW = (NHARTS > 1) ? $clog2(NHARTS) : 1;

   logic [1:0]        state;
   logic [NHARTS-1:0] gnt;
   logic [IW-1:0]     owner;
   logic [IW-1:0]     last_owner;
   logic [NHARTS-1:0] pick;
   logic [IW-1:0]     pick_idx;
   logic [15:0]       hold_cnt;
   logic              hold_err;

   m_rr_pick #(.NHARTS(NHARTS), .IW(IW)) u_pick (
      .req        (w_req),
      .last_owner (last_owner),
      .pick       (pick),
      .pick_idx   (pick_idx)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ARB_IDLE;
         gnt        <= '0;
         owner      <= '0;
         last_owner <= IW'(NHARTS - 1);
         hold_cnt   <= '0;
         hold_err   <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE, ARB_RELEASE: begin
               if (|w_req) begin
                  state    <= ARB_GRANT;
                  gnt      <= pick;
                  owner    <= pick_idx;
                  hold_cnt <= '0;
               end else begin
                  state <= ARB_IDLE;
               end
            end
            ARB_GRANT: begin
               hold_cnt <= sat_inc16(hold_cnt);
               // watchdog only flags; the grant is never revoked
               if (hold_cnt == 16'(MAX_HOLD - 1))
                  hold_err <= 1'b1;
               if (!w_req[owner] && !w_dram_busy) begin
                  state      <= ARB_RELEASE;
                  gnt        <= '0;
                  last_owner <= owner;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   // gnt is zero outside GRANT, so the AND-OR mux yields all-zero DRAM outputs
   always_comb begin
      w_dram_addr  = '0;
      w_dram_wdata = '0;
      w_dram_we    = 1'b0;
      w_dram_le    = 1'b0;
      w_dram_ctrl  = '0;
      w_h_busy     = '1;
      for (int i = 0; i < NHARTS; i++) begin
         w_dram_addr  = w_dram_addr  | ({32{gnt[i]}} & w_h_addr[32*i +: 32]);
         w_dram_wdata = w_dram_wdata | ({32{gnt[i]}} & w_h_wdata[32*i +: 32]);
         w_dram_we    = w_dram_we    | (gnt[i] & w_h_we[i]);
         w_dram_le    = w_dram_le    | (gnt[i] & w_h_le[i]);
         w_dram_ctrl  = w_dram_ctrl  | ({3{gnt[i]}} & w_h_ctrl[3*i +: 3]);
         if (gnt[i])
            w_h_busy[i] = w_dram_busy;
      end
   end

   assign w_gnt      = gnt;
   assign w_grant    = (state == ARB_GRANT) ? 32'(owner) : GRANT_NONE;
   assign w_hold_err = hold_err;

endmodule

// File: tb/tb_m_hart_mem_arbiter.sv
// Bench for the 2-hart DRAM arbiter with an 8-cycle hold watchdog.
module tb_m_hart_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [1:0]  w_req = '0;
   logic [63:0] w_h_addr = {32'h9000_0010, 32'h8000_0000};
   logic [63:0] w_h_wdata = {32'h5A5A_1111, 32'hA5A5_0000};
   logic [1:0]  w_h_we = '0;
   logic [1:0]  w_h_le = '0;
   logic [5:0]  w_h_ctrl = {3'd5, 3'd2};
   logic [1:0]  w_h_busy;
   logic [1:0]  w_gnt;
   logic [31:0] w_grant;
   logic [31:0] w_dram_addr;
   logic [31:0] w_dram_wdata;
   logic        w_dram_we;
   logic        w_dram_le;
   logic [2:0]  w_dram_ctrl;
   logic        w_dram_busy = 1'b0;
   logic        w_hold_err;

   always #5 CLK = ~CLK;

   m_hart_mem_arbiter #(.NHARTS(2), .MAX_HOLD(8)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .w_req        (w_req),
      .w_h_addr     (w_h_addr),
      .w_h_wdata    (w_h_wdata),
      .w_h_we       (w_h_we),
      .w_h_le       (w_h_le),
      .w_h_ctrl     (w_h_ctrl),
      .w_h_busy     (w_h_busy),
      .w_gnt        (w_gnt),
      .w_grant      (w_grant),
      .w_dram_addr  (w_dram_addr),
      .w_dram_wdata (w_dram_wdata),
      .w_dram_we    (w_dram_we),
      .w_dram_le    (w_dram_le),
      .w_dram_ctrl  (w_dram_ctrl),
      .w_dram_busy  (w_dram_busy),
      .w_hold_err   (w_hold_err)
   );

   typedef struct {
      logic [1:0]  gnt;
      logic [31:0] grant;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic        le;
      logic [2:0]  ctrl;
      logic [1:0]  hbusy;
      logic        err;
   } exp_t;

   typedef struct {
      logic [1:0]  we;
      logic [1:0]  le;
      logic        busy;
      logic [31:0] a1;
      logic        dwe;
      logic        dle;
      logic [31:0] daddr;
      logic [1:0]  hbusy;
   } vec_t;

   exp_t  exp_q[$];
   string name_q[$];
   vec_t  tbl[5];
   int    n_chk = 0;
   int    n_pass = 0;
   logic  exp_err = 1'b0;

   // expected outputs for a given owner (has=0: no owner) and current inputs
   function automatic exp_t mk(bit has, logic idx);
      exp_t e;
      e.err = exp_err;
      if (!has) begin
         e.gnt = 2'b00; e.grant = 32'hFFFF_FFFF; e.addr = '0; e.wdata = '0;
         e.we = 1'b0; e.le = 1'b0; e.ctrl = '0; e.hbusy = 2'b11;
      end else begin
         e.gnt   = idx ? 2'b10 : 2'b01;
         e.grant = {31'b0, idx};
         e.addr  = idx ? w_h_addr[63:32]  : w_h_addr[31:0];
         e.wdata = idx ? w_h_wdata[63:32] : w_h_wdata[31:0];
         e.we    = idx ? w_h_we[1] : w_h_we[0];
         e.le    = idx ? w_h_le[1] : w_h_le[0];
         e.ctrl  = idx ? w_h_ctrl[5:3] : w_h_ctrl[2:0];
         e.hbusy = idx ? {w_dram_busy, 1'b1} : {1'b1, w_dram_busy};
      end
      return e;
   endfunction

   task automatic tick();
      exp_t  e;
      string nm;
      @(posedge CLK);
      #1;
      while (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_chk++;
         if (w_gnt === e.gnt && w_grant === e.grant && w_dram_addr === e.addr &&
             w_dram_wdata === e.wdata && w_dram_we === e.we && w_dram_le === e.le &&
             w_dram_ctrl === e.ctrl && w_h_busy === e.hbusy && w_hold_err === e.err)
            n_pass++;
         else
            $display("FAIL %s: got gnt=%b grant=%h addr=%h wdata=%h we=%b le=%b ctrl=%0d hbusy=%b err=%b; want gnt=%b grant=%h addr=%h wdata=%h we=%b le=%b ctrl=%0d hbusy=%b err=%b",
                     nm, w_gnt, w_grant, w_dram_addr, w_dram_wdata, w_dram_we, w_dram_le,
                     w_dram_ctrl, w_h_busy, w_hold_err, e.gnt, e.grant, e.addr, e.wdata,
                     e.we, e.le, e.ctrl, e.hbusy, e.err);
      end
   endtask

   task automatic cyc(string nm, bit has, logic idx);
      exp_q.push_back(mk(has, idx));
      name_q.push_back(nm);
      tick();
   endtask

   initial begin
      tbl[0] = '{2'b01, 2'b00, 1'b0, 32'h2222_0000, 1'b0, 1'b0, 32'h2222_0000, 2'b01};
      tbl[1] = '{2'b10, 2'b00, 1'b1, 32'h2222_0004, 1'b1, 1'b0, 32'h2222_0004, 2'b11};
      tbl[2] = '{2'b00, 2'b10, 1'b0, 32'h3333_0008, 1'b0, 1'b1, 32'h3333_0008, 2'b01};
      tbl[3] = '{2'b11, 2'b01, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'b01};
      tbl[4] = '{2'b01, 2'b01, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0040, 2'b11};

      // reset, then a lone hart0 request
      tick();
      cyc("reset", 1'b0, 1'b0);
      RST = 1'b0;
      w_req = 2'b01;
      cyc("t1_grant0", 1'b1, 1'b0);
      w_req = 2'b00;
      cyc("t1_release", 1'b0, 1'b0);
      cyc("t1_idle", 1'b0, 1'b0);

      // simultaneous requests right after reset: hart0 first, then hart1
      RST = 1'b1;
      cyc("t2_reset", 1'b0, 1'b0);
      RST = 1'b0;
      w_req = 2'b11;
      cyc("t2_grant0", 1'b1, 1'b0);
      w_req = 2'b10;
      cyc("t2_release", 1'b0, 1'b0);
      cyc("t2_grant1", 1'b1, 1'b1);

      // datapath table while hart1 owns the port
      w_h_addr[31:0] = 32'h1111_0000;
      for (int i = 0; i < 5; i++) begin
         w_h_we = tbl[i].we;
         w_h_le = tbl[i].le;
         w_dram_busy = tbl[i].busy;
         w_h_addr[63:32] = tbl[i].a1;
         #1;
         n_chk++;
         if (w_dram_we === tbl[i].dwe && w_dram_le === tbl[i].dle &&
             w_dram_addr === tbl[i].daddr && w_h_busy === tbl[i].hbusy)
            n_pass++;
         else
            $display("FAIL mux_vec%0d: got we=%b le=%b addr=%h hbusy=%b; want we=%b le=%b addr=%h hbusy=%b",
                     i, w_dram_we, w_dram_le, w_dram_addr, w_h_busy,
                     tbl[i].dwe, tbl[i].dle, tbl[i].daddr, tbl[i].hbusy);
      end
      w_h_we = '0;
      w_h_le = '0;
      w_dram_busy = 1'b0;
      w_h_addr = {32'h9000_0010, 32'h8000_0000};
      w_req = 2'b00;
      cyc("t2_release1", 1'b0, 1'b0);
      cyc("t2_idle", 1'b0, 1'b0);

      // owner drops while DRAM stays busy: grant held until busy clears
      w_req = 2'b01;
      cyc("t3_grant0", 1'b1, 1'b0);
      w_req = 2'b00;
      w_dram_busy = 1'b1;
      for (int k = 0; k < 5; k++)
         cyc($sformatf("t3_busyhold%0d", k), 1'b1, 1'b0);
      w_dram_busy = 1'b0;
      cyc("t3_release", 1'b0, 1'b0);
      cyc("t3_idle", 1'b0, 1'b0);

      // sole requester hart1 is re-granted after every release
      for (int k = 0; k < 3; k++) begin
         w_req = 2'b10;
         cyc($sformatf("t4_grant1_%0d", k), 1'b1, 1'b1);
         w_req = 2'b00;
         cyc($sformatf("t4_release_%0d", k), 1'b0, 1'b0);
      end
      cyc("t4_idle", 1'b0, 1'b0);

      // hold watchdog: flag rises after 8 grant cycles and is sticky
      w_req = 2'b01;
      cyc("t5_grant_c1", 1'b1, 1'b0);
      for (int k = 2; k <= 20; k++) begin
         exp_err = (k >= 9);
         cyc($sformatf("t5_hold_c%0d", k), 1'b1, 1'b0);
      end
      w_req = 2'b00;
      cyc("t5_release", 1'b0, 1'b0);
      cyc("t5_idle_sticky", 1'b0, 1'b0);

      // reset while hart1 writes: outputs drop, hart0 wins next tie
      w_req = 2'b10;
      w_h_we = 2'b10;
      cyc("t6_grant1_we", 1'b1, 1'b1);
      RST = 1'b1;
      exp_err = 1'b0;
      cyc("t6_reset", 1'b0, 1'b0);
      RST = 1'b0;
      w_h_we = 2'b00;
      w_req = 2'b11;
      cyc("t6_grant0", 1'b1, 1'b0);
      w_req = 2'b00;
      cyc("t6_release", 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
